// File: rtl/eq_pair_tx.sv
// eq_pair_tx: serialises a word pair LSB first on i0/i1, each bit pair held DVSR cycles.
// Define EQ_PAIR_TX_CMP_EN to build the bit-pair mismatch counter (eq_all / mis_cnt).
module eq_pair_tx #(
    parameter int unsigned W    = 8,
    parameter int unsigned DVSR = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   in_vld,
    input  logic [W-1:0]           a_word,
    input  logic [W-1:0]           b_word,
    output logic                   in_rdy,
    output logic                   i0,
    output logic                   i1,
    output logic                   bit_stb,
    output logic                   busy,
    output logic                   done_tick,
    output logic                   eq_all,
    output logic [$clog2(W+1)-1:0] mis_cnt
);
    localparam int unsigned IW = $clog2(W);
    localparam int unsigned DW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(W - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DVSR - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [W-1:0]  a_sh_q, a_sh_d;
    logic [W-1:0]  b_sh_q, b_sh_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [DW-1:0] div_q, div_d;
    logic          accept;
    logic          div_last;
    logic          bit_last;

    assign accept   = in_vld & in_rdy;
    assign div_last = (div_q == DIV_LAST);
    assign bit_last = (idx_q == IDX_LAST);

    // Outputs decode from state so an asynchronous reset zeroes them immediately.
    always_comb begin
        in_rdy    = (state_q == IDLE) && !clr;
        busy      = (state_q == SHIFT);
        i0        = busy & a_sh_q[0];
        i1        = busy & b_sh_q[0];
        bit_stb   = busy && (div_q == '0);
        done_tick = busy && div_last && bit_last && !clr;
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        idx_d   = idx_q;
        div_d   = div_q;
        if (clr) begin
            state_d = IDLE;
            a_sh_d  = '0;
            b_sh_d  = '0;
            idx_d   = '0;
            div_d   = '0;
        end else if (state_q == IDLE) begin
            if (accept) begin
                state_d = SHIFT;
                a_sh_d  = a_word;
                b_sh_d  = b_word;
                idx_d   = '0;
                div_d   = '0;
            end
        end else if (div_last) begin
            div_d = '0;
            if (bit_last) begin
                state_d = IDLE;
                a_sh_d  = '0;
                b_sh_d  = '0;
                idx_d   = '0;
            end else begin
                idx_d  = idx_q + 1'b1;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            idx_q   <= '0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            idx_q   <= idx_d;
            div_q   <= div_d;
        end
    end

`ifdef EQ_PAIR_TX_CMP_EN
    localparam int unsigned CW = $clog2(W + 1);

    logic [CW-1:0] mis_q, mis_d;
    logic          eq_q, eq_d;

    // eq_all uses the next count so a mismatch on the final bit (DVSR = 1) is included.
    always_comb begin
        mis_d = mis_q;
        eq_d  = eq_q;
        if (accept) begin
            mis_d = '0;
            eq_d  = 1'b0;
        end else if (bit_stb && (i0 != i1)) begin
            mis_d = mis_q + 1'b1;
        end
        if (done_tick) begin
            eq_d = (mis_d == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mis_q <= '0;
            eq_q  <= 1'b0;
        end else begin
            mis_q <= mis_d;
            eq_q  <= eq_d;
        end
    end

    assign eq_all  = eq_q;
    assign mis_cnt = mis_q;
`else
    assign eq_all  = 1'b0;
    assign mis_cnt = '0;
`endif

endmodule

// File: tb/tb_eq_pair_tx.sv
// tb_eq_pair_tx: two eq_pair_tx instances (W=8/DVSR=4 and W=2/DVSR=1) checked against a
// transfer-level reference model with a result scoreboard popped on each done_tick.
module tb_eq_pair_tx;
    localparam int W0 = 8;
    localparam int D0 = 4;
    localparam int W1 = 2;
    localparam int D1 = 1;

    typedef struct packed {
        logic       eq;
        logic [3:0] mis;
    } exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] clr   = '0;
    logic [1:0] vld   = '0;
    logic [7:0] aw [2];
    logic [7:0] bw [2];
    logic [1:0] rdy, o0, o1, stb, bsy, dn, eq;
    logic [3:0] mis0;
    logic [1:0] mis1;

    always #5 clk = ~clk;

    eq_pair_tx #(.W(W0), .DVSR(D0)) dut0 (
        .clk(clk), .reset(reset), .clr(clr[0]), .in_vld(vld[0]),
        .a_word(aw[0]), .b_word(bw[0]), .in_rdy(rdy[0]), .i0(o0[0]), .i1(o1[0]),
        .bit_stb(stb[0]), .busy(bsy[0]), .done_tick(dn[0]), .eq_all(eq[0]), .mis_cnt(mis0)
    );

    eq_pair_tx #(.W(W1), .DVSR(D1)) dut1 (
        .clk(clk), .reset(reset), .clr(clr[1]), .in_vld(vld[1]),
        .a_word(aw[1][1:0]), .b_word(bw[1][1:0]), .in_rdy(rdy[1]), .i0(o0[1]), .i1(o1[1]),
        .bit_stb(stb[1]), .busy(bsy[1]), .done_tick(dn[1]), .eq_all(eq[1]), .mis_cnt(mis1)
    );

    int         total = 0;
    int         bad   = 0;
    int         m_t [2] = '{-1, -1};  // cycle index within the transfer, -1 when idle
    logic [7:0] m_a [2];
    logic [7:0] m_b [2];
    exp_t       held [2];
    bit         held_v [2];
    bit         rst_prev   = 1'b0;
    bit         finish_req = 1'b0;
    exp_t       q0 [$];
    exp_t       q1 [$];

    function automatic int wof(int i);
        return (i == 0) ? W0 : W1;
    endfunction

    function automatic int dof(int i);
        return (i == 0) ? D0 : D1;
    endfunction

    function automatic int q_size(int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void q_push(int i, exp_t e);
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction

    function automatic exp_t q_pop(int i);
        if (i == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic void q_drop(int i);
        if (i == 0 && q0.size() > 0) q0.delete(q0.size() - 1);
        if (i == 1 && q1.size() > 0) q1.delete(q1.size() - 1);
    endfunction

    function automatic void q_flush(int i);
        if (i == 0) q0.delete();
        else q1.delete();
    endfunction

    function automatic exp_t ref_result(int i, logic [7:0] a, logic [7:0] b);
        exp_t       e;
        logic [8:0] mask;
        int         n;
        mask = (9'd1 << wof(i)) - 9'd1;
        n    = $countones((a ^ b) & mask[7:0]);
        e    = '0;
`ifdef EQ_PAIR_TX_CMP_EN
        e.mis = 4'(n);
        e.eq  = (n == 0);
`else
        if (n < 0) e.mis = 4'd0;
`endif
        return e;
    endfunction

    function automatic void check(string nm, int i, logic [15:0] got, logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s[%0d] t=%0t got=%h want=%h", nm, i, $time, got, want);
        end
    endfunction

    function automatic void step(int i);
        int         w, d, k, c;
        logic       busy_e;
        logic [5:0] want, got;
        logic [3:0] mis_i;
        w = wof(i);
        d = dof(i);
        if (reset) begin
            m_t[i]    = -1;
            q_flush(i);
            held[i]   = '0;
            held_v[i] = 1'b1;
        end
        busy_e = (m_t[i] >= 0);
        k      = busy_e ? m_t[i] / d : 0;
        c      = busy_e ? m_t[i] % d : 0;
        want   = {!busy_e && !clr[i], busy_e, busy_e && m_a[i][k], busy_e && m_b[i][k],
                  busy_e && (c == 0), busy_e && (m_t[i] == w * d - 1) && !clr[i]};
        got    = {rdy[i], bsy[i], o0[i], o1[i], stb[i], dn[i]};
        check("cycle", i, 16'(got), 16'(want));

        mis_i = (i == 0) ? mis0 : {2'b00, mis1};
        if (dn[i] && q_size(i) > 0) begin
            held[i]   = q_pop(i);
            held_v[i] = 1'b1;
        end else if (!busy_e && held_v[i]) begin
            check("result", i, 16'({eq[i], mis_i}), 16'(held[i]));
        end

        if (!reset) begin
            if (clr[i]) begin
                if (busy_e) begin
                    q_drop(i);
                    held_v[i] = 1'b0;
                end
                m_t[i] = -1;
            end else if (!busy_e) begin
                if (vld[i]) begin
                    m_t[i]    = 0;
                    m_a[i]    = aw[i];
                    m_b[i]    = bw[i];
                    q_push(i, ref_result(i, aw[i], bw[i]));
                    held_v[i] = 1'b0;
                end
            end else if (m_t[i] == w * d - 1) begin
                m_t[i] = -1;
            end else begin
                m_t[i] = m_t[i] + 1;
            end
        end
    endfunction

    // Reset rises only between edges, so a posedge-reset wakeup is the asynchronous path.
    always @(negedge clk or posedge reset) begin
        if (reset && !rst_prev) begin
            rst_prev = 1'b1;
            #1;
            check("async_reset", 0, 16'({bsy, o0, o1, stb, dn, eq}), 16'd0);
            check("async_reset_mis", 0, 16'({mis0, mis1}), 16'd0);
        end else begin
            rst_prev = reset;
            if (finish_req) begin
                check("queue_empty", 0, 16'(q_size(0)), 16'd0);
                check("queue_empty", 1, 16'(q_size(1)), 16'd0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
            for (int i = 0; i < 2; i++) step(i);
        end
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        aw[0] = '0; bw[0] = '0; aw[1] = '0; bw[1] = '0;
        #2 reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(2);

        vld = 2'b11;
        aw[0] = 8'hA5; bw[0] = 8'hA5; aw[1] = 8'h02; bw[1] = 8'h03;
        cyc(1);
        vld = '0;
        cyc(35);

        vld[0] = 1'b1; aw[0] = 8'hFF; bw[0] = 8'h0F;
        cyc(1);
        vld[0] = 1'b0;
        cyc(35);

        // in_vld held across back-to-back transfers while the words keep changing
        vld[0] = 1'b1;
        repeat (70) begin
            aw[0] = 8'($urandom);
            bw[0] = 8'($urandom);
            cyc(1);
        end
        vld[0] = 1'b0;
        cyc(35);

        // abort on SHIFT cycle 10, then clr together with in_vld while idle
        vld[0] = 1'b1; aw[0] = 8'h3C; bw[0] = 8'h5A;
        cyc(1);
        vld[0] = 1'b0;
        cyc(10);
        clr[0] = 1'b1;
        cyc(1);
        vld[0] = 1'b1;
        cyc(1);
        clr[0] = 1'b0; vld[0] = 1'b0;
        cyc(3);

        vld = 2'b11;
        aw[0] = 8'h81; bw[0] = 8'h7E; aw[1] = 8'h01; bw[1] = 8'h02;
        cyc(1);
        vld = '0;
        cyc(5);
        @(negedge clk);
        #2 reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(40);

        repeat (1500) begin
            for (int i = 0; i < 2; i++) begin
                vld[i] = ($urandom_range(0, 2) == 0);
                clr[i] = ($urandom_range(0, 49) == 0);
                aw[i]  = 8'($urandom);
                bw[i]  = 8'($urandom);
            end
            cyc(1);
        end
        vld = '0;
        clr = '0;
        cyc(40);
        finish_req = 1'b1;
    end
endmodule
